scr1_ahb_sram_resp: RTL
=======================

// Module: scr1_ahb_sram_resp
// PURPOSE
//  Synthesizable AHB-Lite single-slave responder backed by a word-organised SRAM array.
//  Answers the SCR1 imem/dmem AHB initiator ports.
//  Programmable wait states, precise byte-lane writes, two-cycle ERROR responses.
//  Used as on-chip TCM stand-in for FPGA builds and as a synthesizable test memory.
// PARAMETERS
//  SCR1_MEM_POWER_SIZE  16  log2 of memory size in bytes; words = 2**(SCR1_MEM_POWER_SIZE-2)
//  WAIT_W               4   width of wait_cfg; max 2**WAIT_W-1 wait states
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  rst_n      in   1   synchronous active-low reset
//  wait_cfg   in   WAIT_W  wait states per OKAY transfer, sampled in address phase
//  htrans     in   2   AHB transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
//  haddr      in   32  byte address
//  hsize      in   3   0 byte, 1 half, 2 word; others illegal
//  hwrite     in   1   1 write, 0 read
//  hwdata     in   32  write data, valid in data phase
//  hready     out  1   bus ready (single slave: also the master's HREADY input)
//  hrdata     out  32  read data
//  hresp      out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, hready=1, hresp=0, hrdata=0; pending write discarded.
//  Memory contents are not reset.
//  Address phase is accepted when hready=1 and htrans[1]=1.
//  On accept, register haddr, hsize, hwrite and wait_cfg.
//  IDLE/BUSY, or hready=0: address inputs ignored; no data phase; hready stays 1 if state IDLE.
//  Legality check at accept; ERROR if any of:
//   - hsize>2
//   - hsize=1 with haddr[0]=1
//   - hsize=2 with haddr[1:0]!=0
//   - out-of-range (see CONFIGURATION)
//  FSM: IDLE, WAIT, DATA, ERR1, ERR2.
//   IDLE: legal accept -> WAIT if wait_cfg!=0 else DATA; illegal accept -> ERR1.
//   WAIT: hready=0, hresp=0; counter loaded with wait_cfg-1 and decremented; at 0 -> DATA.
//   DATA: hready=1, hresp=0; transfer completes this cycle.
//    Read: hrdata = mem[addr_q[P-1:2]], full word, no lane masking.
//    Write: hwdata lanes written at this posedge.
//     byte: lane addr_q[1:0]; half: lanes {addr_q[1],0}+{0,1}; word: all lanes.
//    New address phase may be accepted in the same cycle (pipelined):
//     next state WAIT/DATA/ERR1 per new transfer, else IDLE.
//   ERR1: hready=0, hresp=1, no memory access -> ERR2.
//   ERR2: hready=1, hresp=1; accepts a new address phase like DATA.
//  Latency: zero-wait back-to-back NONSEQ/SEQ sustains one transfer per cycle.
//  Read after write to the same word sees new data (write lands before following data phase).
//  hrdata=0 in every cycle that is not a completing read DATA cycle.
//  wait_cfg changes mid-transfer have no effect on the current transfer.
//  rst_n low during WAIT/ERR1: abort; next cycle IDLE with hready=1.
//  haddr bits above SCR1_MEM_POWER_SIZE-1 feed only the range check.
// CONFIGURATION
//  SCR1_AHB_RESP_RANGE_ERR_EN defined:
//   access with haddr >= 2**SCR1_MEM_POWER_SIZE gets the ERROR response (ERR1/ERR2).
//   Writes are suppressed; hrdata=0.
//  Not defined: upper address bits ignored; access wraps modulo memory size; OKAY response.
// TESTING
//  1 Reset: rst_n=0 2 cycles -> hready=1, hresp=0, hrdata=0.
//    Write 0x12345678 to 0x0, read 0x0 -> 0x12345678.
//  2 wait_cfg=3, word read 0x40 -> hready low exactly 3 cycles, data on 4th.
//    wait_cfg=0 back-to-back reads 0x40,0x44 -> 2 transfers in 2 cycles.
//  3 Word 0x100=0xAABBCCDD; byte write 0x11 to 0x102; half write 0x2233 to 0x100
//    -> read 0x100 = 0xAA112233.
//  4 Half write to 0x201 -> hready=0/hresp=1 then hready=1/hresp=1; word 0x200 unchanged.
//    hsize=3 -> same ERROR pattern.
//  5 Address 0x0001_0000, SCR1_MEM_POWER_SIZE=16:
//    macro on -> ERROR, mem[0] unchanged.
//    Macro off -> write 0xCAFEF00D aliases to 0x0; read 0x0 = 0xCAFEF00D.
//  6 rst_n=0 during WAIT of a write -> next cycle IDLE, hready=1; target word unchanged.

Source files
------------

// File: rtl/scr1_ahb_sram_resp.sv
// ============================================================================
// Module   : scr1_ahb_sram_resp
// Brief    : AHB-Lite single-slave SRAM responder with programmable wait
//            states, byte-lane writes and two-cycle ERROR responses.
//            Optional macro SCR1_AHB_RESP_RANGE_ERR_EN: out-of-range -> ERROR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scr1_ahb_sram_resp #(
    parameter int SCR1_MEM_POWER_SIZE = 16,
    parameter int WAIT_W              = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WAIT_W-1:0] wait_cfg,
    input  logic [1:0]        htrans,
    input  logic [31:0]       haddr,
    input  logic [2:0]        hsize,
    input  logic              hwrite,
    input  logic [31:0]       hwdata,
    output logic              hready,
    output logic [31:0]       hrdata,
    output logic              hresp
);

    localparam int P     = SCR1_MEM_POWER_SIZE;
    localparam int WORDS = 2 ** (P - 2);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [P-1:0]      addr_q,  addr_d;
    logic [1:0]        size_q,  size_d;
    logic              write_q, write_d;
    logic [WAIT_W-1:0] cnt_q,   cnt_d;

    logic [31:0]       mem [WORDS];

    logic              size_ok;
    logic              range_ok;
    logic              take_new;
    logic              mem_we;
    logic [3:0]        byte_en;

    always_comb begin
        case (hsize)
            3'd0:    size_ok = 1'b1;
            3'd1:    size_ok = ~haddr[0];
            3'd2:    size_ok = (haddr[1:0] == 2'b00);
            default: size_ok = 1'b0;
        endcase
    end

`ifdef SCR1_AHB_RESP_RANGE_ERR_EN
    assign range_ok = (haddr[31:P] == '0);
`else
    // Upper address bits are deliberately dropped so accesses wrap.
    logic addr_hi_unused;
    assign addr_hi_unused = |haddr[31:P];
    assign range_ok       = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        cnt_d    = cnt_q;
        hready   = 1'b1;
        hresp    = 1'b0;
        hrdata   = '0;
        mem_we   = 1'b0;
        take_new = 1'b0;

        case (state_q)
            ST_IDLE: take_new = 1'b1;
            ST_WAIT: begin
                hready = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            ST_DATA: begin
                if (write_q) begin
                    mem_we = 1'b1;
                end else begin
                    hrdata = mem[addr_q[P-1:2]];
                end
                take_new = 1'b1;
            end
            ST_ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                hresp    = 1'b1;
                take_new = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // hready is high in every take_new state, so htrans[1] alone accepts.
        if (take_new) begin
            if (htrans[1]) begin
                addr_d  = haddr[P-1:0];
                size_d  = hsize[1:0];
                write_d = hwrite;
                cnt_d   = wait_cfg - WAIT_W'(1);
                if (!(size_ok && range_ok)) begin
                    state_d = ST_ERR1;
                end else if (wait_cfg != '0) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DATA;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    byte_en = 4'b0001 << addr_q[1:0];
            2'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is not reset; a write caught by reset is simply dropped.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[addr_q[P-1:2]][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire
